mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised memory-access stage for the RISC-V pipeline. Carries ALU results from EX through to WB and executes loads and stores against a single-ported data-memory bus with a request/acknowledge handshake. Also does byte-lane steering, load sign/zero extension, and raises a pipeline stall while a bus access is outstanding. All outputs are registered, so the stage also acts as the MEM/WB register.

## Interface
- REG_ADDR_W, 5: destination register address width.
- XLEN, 32: data/address width; only 32 is supported, giving 4 byte lanes.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- valid_i  in  1  EX presents an instruction.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  register write enable.
- wdata_i  in  XLEN  ALU result, used for non-memory ops.
- mem_op_i  in  2  operation: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- funct3_i  in  3  RISC-V size/sign code.
- mem_addr_i  in  XLEN  effective byte address.
- store_data_i  in  XLEN  rs2 value.
- wd_o  out  REG_ADDR_W  destination to WB.
- wreg_o  out  1  write enable to WB.
- wdata_o  out  XLEN  result to WB.
- valid_o  out  1  result valid; one cycle per retired instruction.
- stall_o  out  1  stage busy; upstream must hold all *_i stable.
- exc_o  out  1  misaligned access, one-cycle pulse (MEM_MISALIGN_EN only).
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  XLEN  word-aligned address, with bits [1:0] = 0.
- mem_sel_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_rdata_i  in  XLEN  read data, valid in the ack cycle.
- mem_ack_i  in  1  access complete.

## Operation
- States:
  - IDLE: accepts input when valid_i=1.
  - BUSY: bus request outstanding.
- Non-memory op accepted in IDLE: the next cycle has valid_o=1, with wd_o, wreg_o and wdata_o copied from the inputs.
- valid_i=0 in IDLE: the next cycle has valid_o=0 and wreg_o=0. wd_o and wdata_o are don't-care but are driven 0.
- Load or store accepted in IDLE:
  - Transition to BUSY.
  - Register address, sel, wdata, funct3, wd and wreg.
  - mem_req_o=1 from the next cycle.
- Byte lanes use a = mem_addr_i[1:0]:
  - Byte (funct3 x00): sel = 0001<<a.
  - Half (x01): sel = 0011<<(2*a[1]).
  - Word (010): sel = 1111.
- Store data replication:
  - Byte stores replicate store_data_i[7:0] into all 4 lanes.
  - Half stores replicate store_data_i[15:0] into both halves.
- BUSY with mem_ack_i=1: go to IDLE, and mem_req_o drops the next cycle.
  - Load: wdata_o is the lane selected by the registered a.
    - LB/LH (000/001) sign-extend.
    - LBU/LHU (100/101) zero-extend.
    - LW (010) passes the word through.
    - wreg_o comes from the registered wreg_i.
  - Store: wreg_o=0 and wdata_o=0.
  - In both cases valid_o=1 for one cycle.
- Reserved funct3 values (011, 110, 111) are treated as a word access.
- mem_ack_i is ignored while mem_req_o=0.
- stall_o = (state==BUSY).
- rst=0 at an edge returns the block to IDLE, even mid-access. The request is abandoned, and the bus must tolerate a dropped request.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Non-memory op latency: 1 cycle, giving throughput of 1 per cycle.
- Memory op accepted in cycle N:
  - mem_req_o and stall_o are high from N+1.
  - Ack in cycle M ≥ N+1 gives the result in M+1.
  - stall_o is low in M+1, and the held input is accepted in M+1.
- Minimum memory-op latency is 2 cycles.
- Bus outputs are held constant while mem_req_o=1.

## Configuration
- MEM_MISALIGN_EN is defined:
  - A load or store that is misaligned is detected at acceptance. Misaligned means a half access with a[0]=1, or a word access with a≠0.
  - No bus request is made and the block stays in IDLE.
  - The next cycle has exc_o=1, valid_o=1 and wreg_o=0.
- MEM_MISALIGN_EN is undefined:
  - exc_o is tied to 0.
  - Half accesses ignore a[0]; word accesses ignore a[1:0].
  - The access proceeds normally.

## Test plan
- Reset, then ALU op: valid_i=1, wd_i=5, wreg_i=1, wdata_i=0x1234 -> the next cycle has valid_o=1, wd_o=5, wdata_o=0x1234, stall_o=0.
- LB at addr 0x103 with mem_rdata_i=0x80FF_FF7F, ack 3 cycles after req -> mem_addr_o=0x100 and sel=1000; stall_o is held for 3 cycles; wdata_o=0xFFFF_FF80. Repeat with LBU -> wdata_o=0x0000_0080.
- SH at addr 0x22, store_data_i=0xDEAD_BEEF -> mem_we_o=1, sel=1100, mem_wdata_o=0xBEEF_BEEF; on retire, valid_o=1 and wreg_o=0.
- Back-to-back LW then ALU op held under stall -> the ALU op retires exactly one cycle after the LW result, and nothing is lost or duplicated.
- rst=0 while BUSY -> the next cycle has mem_req_o=0, stall_o=0 and valid_o=0; a late mem_ack_i is ignored.
- With MEM_MISALIGN_EN: LW at 0x102 -> no mem_req_o, exc_o=1 for one cycle, wreg_o=0. Without it: the same access gives mem_addr_o=0x100 and sel=1111.

Source files
------------

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - single-ported data-memory bus with request/acknowledge handshake
interface mem_lsu_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      sel;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM stage / MEM-WB register with byte-lane steering; optional MEM_MISALIGN_EN traps misaligned accesses
module mem_lsu #(
    parameter int REG_ADDR_W = 5,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [1:0]            mem_op_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       mem_addr_i,
    input  logic [XLEN-1:0]       store_data_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic                  valid_o,
    output logic                  stall_o,
    output logic                  exc_o,
    mem_lsu_if.master             mem
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;

    logic [1:0]            a;
    logic                  is_mem;
    logic                  is_byte;
    logic                  is_half;
    logic                  misalign;
    logic                  start;
    logic [3:0]            sel_d;
    logic [XLEN-1:0]       wdata_rep;

    logic                  we_q;
    logic [XLEN-1:0]       addr_q;
    logic [3:0]            sel_q;
    logic [XLEN-1:0]       mwdata_q;
    logic [2:0]            f3_q;
    logic [1:0]            a_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;

    logic [XLEN-1:0]       shifted;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [XLEN-1:0]       load_val;

    assign a       = mem_addr_i[1:0];
    assign is_mem  = (mem_op_i == 2'b01) || (mem_op_i == 2'b10);
    assign is_byte = (funct3_i[1:0] == 2'b00);
    assign is_half = (funct3_i[1:0] == 2'b01);

`ifdef MEM_MISALIGN_EN
    assign misalign = is_half ? a[0] : (!is_byte && (a != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign start = (state_q == IDLE) && valid_i && is_mem && !misalign;

    // Reserved size codes fall into the word case.
    always_comb begin
        sel_d     = 4'b1111;
        wdata_rep = store_data_i;
        if (is_byte) begin
            sel_d     = 4'b0001 << a;
            wdata_rep = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            sel_d     = a[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{store_data_i[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = BUSY;
            BUSY:    if (mem.ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_o   = (state_q == BUSY);
    assign mem.req   = (state_q == BUSY);
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.sel   = sel_q;
    assign mem.wdata = mwdata_q;

    always_comb begin
        shifted  = mem.rdata >> {a_q, 3'b000};
        byte_v   = shifted[7:0];
        half_v   = a_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
        load_val = mem.rdata;
        case (f3_q[1:0])
            2'b00:   load_val = {{(XLEN-8){~f3_q[2] & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{(XLEN-16){~f3_q[2] & half_v[15]}}, half_v};
            default: load_val = mem.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o  <= 1'b0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
            wdata_o  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= 4'b0000;
            mwdata_q <= '0;
            f3_q     <= 3'b000;
            a_q      <= 2'b00;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
            if (state_q == IDLE) begin
                if (valid_i && !is_mem) begin
                    valid_o <= 1'b1;
                    wd_o    <= wd_i;
                    wreg_o  <= wreg_i;
                    wdata_o <= wdata_i;
                end else if (valid_i && misalign) begin
                    valid_o <= 1'b1;
                    wd_o    <= wd_i;
                end else if (start) begin
                    we_q     <= (mem_op_i == 2'b10);
                    addr_q   <= {mem_addr_i[XLEN-1:2], 2'b00};
                    sel_q    <= sel_d;
                    mwdata_q <= wdata_rep;
                    f3_q     <= funct3_i;
                    a_q      <= a;
                    wd_q     <= wd_i;
                    wreg_q   <= wreg_i;
                end
            end else if (mem.ack) begin
                valid_o <= 1'b1;
                wd_o    <= wd_q;
                if (!we_q) begin
                    wreg_o  <= wreg_q;
                    wdata_o <= load_val;
                end
            end
        end
    end

`ifdef MEM_MISALIGN_EN
    logic exc_q;

    always_ff @(posedge clk) begin
        if (!rst) exc_q <= 1'b0;
        else      exc_q <= (state_q == IDLE) && valid_i && is_mem && misalign;
    end

    assign exc_o = exc_q;
`else
    assign exc_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed scoreboard bench for mem_lsu
module tb_mem_lsu;
    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [1:0]  mem_op_i;
    logic [2:0]  funct3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        valid_o;
    logic        stall_o;
    logic        exc_o;

    mem_lsu_if bus ();

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .mem_op_i     (mem_op_i),
        .funct3_i     (funct3_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .valid_o      (valid_o),
        .stall_o      (stall_o),
        .exc_o        (exc_o),
        .mem          (bus)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        exc;
    } exp_t;

    exp_t        sb[$];
    int          vcyc[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          ack_delay = 1;
    int          cnt = 0;
    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] rdata_val = 32'h0;

    assign bus.rdata = rdata_val;
    assign bus.ack   = resp_ack | force_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Bus model: acknowledge in the ack_delay-th cycle of a request.
    always @(negedge clk) begin
        if (bus.req) begin
            cnt      = cnt + 1;
            resp_ack = (cnt == ack_delay);
        end else begin
            cnt      = 0;
            resp_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (valid_o) begin
            exp_t e;
            vcyc.push_back(cyc);
            chk("unexpected_valid", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_wreg", 32'(wreg_o), 32'(e.wreg));
                chk("sb_wdata", wdata_o, e.wdata);
                chk("sb_exc", 32'(exc_o), 32'(e.exc));
                if (e.wreg) chk("sb_wd", 32'(wd_o), 32'(e.wd));
            end
        end
    end

    task automatic push(input logic [4:0] wd, input logic wr, input logic [31:0] wdat, input logic ex);
        exp_t e;
        e.wd = wd; e.wreg = wr; e.wdata = wdat; e.exc = ex;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdat);
        bit ok = 0;
        valid_i = 1'b1; mem_op_i = op; funct3_i = f3; mem_addr_i = addr;
        store_data_i = sd; wd_i = wd; wreg_i = wr; wdata_i = wdat;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_o) begin ok = 1; break; end
        end
        chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0; mem_op_i = 2'b00;
    endtask

    // Called at a negedge with stall_o high; returns at posedge+1.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100 && stall_o; i++) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int d;
        rst = 1'b0; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        mem_op_i = 2'b00; funct3_i = 3'b000; mem_addr_i = '0; store_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_exc", 32'(exc_o), 32'd0);
        chk("rst_bus", {27'd0, bus.req, bus.we, bus.sel == 4'd0, bus.addr == 32'd0, bus.wdata == 32'd0}, 32'd7);
        @(posedge clk); #1;
        rst = 1'b1;

        push(5'd5, 1'b1, 32'h1234, 1'b0);
        send(2'b00, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        @(negedge clk);
        chk("alu_stall", 32'(stall_o), 32'd0);
        chk("alu_valid", 32'(valid_o), 32'd1);
        @(posedge clk); #1;

        push(5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0);
        send(2'b11, 3'b010, 32'h10, 32'h0, 5'd31, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rsvd_op_noreq", 32'(bus.req), 32'd0);
        @(posedge clk); #1;

        rdata_val = 32'h80FF_FF7F; ack_delay = 3;
        push(5'd7, 1'b1, 32'hFFFF_FF80, 1'b0);
        send(2'b01, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0);
        @(negedge clk);
        chk("lb_req", 32'(bus.req), 32'd1);
        chk("lb_we", 32'(bus.we), 32'd0);
        chk("lb_addr", bus.addr, 32'h100);
        chk("lb_sel", 32'(bus.sel), 32'b1000);
        wait_idle(n);
        chk("lb_stall_cycles", n, 32'd3);

        push(5'd8, 1'b1, 32'h0000_0080, 1'b0);
        send(2'b01, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1, 32'h0);
        @(negedge clk);
        wait_idle(n);
        chk("lbu_stall_cycles", n, 32'd3);

        ack_delay = 2;
        push(5'd3, 1'b0, 32'h0, 1'b0);
        send(2'b10, 3'b001, 32'h22, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0);
        @(negedge clk);
        chk("sh_we", 32'(bus.we), 32'd1);
        chk("sh_sel", 32'(bus.sel), 32'b1100);
        chk("sh_wdata", bus.wdata, 32'hBEEF_BEEF);
        chk("sh_addr", bus.addr, 32'h20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sh_hold_wdata", bus.wdata, 32'hBEEF_BEEF);
        wait_idle(n);

        rdata_val = 32'h8001_1234; ack_delay = 1;
        push(5'd10, 1'b1, 32'hFFFF_8001, 1'b0);
        send(2'b01, 3'b001, 32'h102, 32'h0, 5'd10, 1'b1, 32'h0);
        @(negedge clk);
        chk("lh_sel", 32'(bus.sel), 32'b1100);
        wait_idle(n);

        rdata_val = 32'hCAFE_F00D; ack_delay = 1;
        push(5'd12, 1'b1, 32'hCAFE_F00D, 1'b0);
        send(2'b01, 3'b010, 32'h40, 32'h0, 5'd12, 1'b1, 32'h0);
        push(5'd13, 1'b1, 32'h55, 1'b0);
        send(2'b00, 3'b000, 32'h0, 32'h0, 5'd13, 1'b1, 32'h55);
        @(negedge clk);
        @(posedge clk); #1;
        chk("b2b_count", 32'(vcyc.size() >= 2), 32'd1);
        d = (vcyc.size() >= 2) ? vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2] : 0;
        chk("b2b_spacing", d, 32'd1);

        ack_delay = 50;
        send(2'b01, 3'b010, 32'h80, 32'h0, 5'd14, 1'b1, 32'h0);
        @(negedge clk);
        chk("abort_req_before", 32'(bus.req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req", 32'(bus.req), 32'd0);
        chk("abort_stall", 32'(stall_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_ack_valid", 32'(valid_o), 32'd0);
            chk("late_ack_stall", 32'(stall_o), 32'd0);
        end
        @(posedge clk); #1;
        force_ack = 1'b0;

`ifdef MEM_MISALIGN_EN
        push(5'd9, 1'b0, 32'h0, 1'b1);
        send(2'b01, 3'b010, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0);
        @(negedge clk);
        chk("mis_noreq", 32'(bus.req), 32'd0);
        chk("mis_exc", 32'(exc_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_exc_pulse", 32'(exc_o), 32'd0);
        chk("mis_noreq_after", 32'(bus.req), 32'd0);
        @(posedge clk); #1;
`else
        rdata_val = 32'h1122_3344; ack_delay = 2;
        push(5'd9, 1'b1, 32'h1122_3344, 1'b0);
        send(2'b01, 3'b010, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0);
        @(negedge clk);
        chk("lw_unal_addr", bus.addr, 32'h100);
        chk("lw_unal_sel", 32'(bus.sel), 32'b1111);
        chk("lw_unal_exc", 32'(exc_o), 32'd0);
        wait_idle(n);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
